// File: rtl/aud_pkg.sv
// Shared types and constants for the WM8731 audio transmit path.
package aud_pkg;

  localparam int AUD_DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } aud_tx_state_t;

endpackage

// File: rtl/aud_edge_sync.sv
// Two-flop synchronizer for a codec clock pin with single-cycle rise/fall pulses.
module aud_edge_sync (
  input  logic CLOCK_50,
  input  logic RST,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;
  logic [1:0] prime_cnt;
  logic       primed;

  // Pulses are held off until the pipeline holds real pin samples, so a pin
  // that is already high when reset releases is not mistaken for an edge.
  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      sync_q    <= '0;
      prime_cnt <= '0;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
      if (prime_cnt != 2'd3) prime_cnt <= prime_cnt + 2'd1;
    end
  end

  assign primed = (prime_cnt == 2'd3);
  assign rise   = primed &  sync_q[1] & ~sync_q[2];
  assign fall   = primed & ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/aud_dac_tx.sv
// WM8731 DAC transmitter: one staged frame ahead, left-justified MSB-first per channel.
// Define AUD_DAC_TX_HOLD_EN to retransmit the previous frame on underrun instead of silence.
module aud_dac_tx
  import aud_pkg::*;
#(
  parameter int DW = AUD_DW
) (
  input  logic          CLOCK_50,
  input  logic          RST,
  input  logic          AUD_BCLK,
  input  logic          AUD_DACLRCK,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_left,
  input  logic [DW-1:0] in_right,
  output logic          AUD_DACDAT,
  output logic          frame_start,
  output logic          underrun
);

  localparam int CW = $clog2(DW + 1);

  logic bclk_rise_unused, bclk_fall, lrck_rise, lrck_fall;

  aud_edge_sync u_bclk_sync (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .async_in (AUD_BCLK),
    .rise     (bclk_rise_unused),
    .fall     (bclk_fall)
  );

  aud_edge_sync u_lrck_sync (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .async_in (AUD_DACLRCK),
    .rise     (lrck_rise),
    .fall     (lrck_fall)
  );

  aud_tx_state_t state, state_n;
  logic [DW-1:0] stg_l, stg_r, act_l, act_r, sh;
  logic [DW-1:0] stg_l_n, stg_r_n, act_l_n, act_r_n, sh_n;
  logic          stg_full, stg_full_n;
  logic [CW-1:0] bitcnt, bitcnt_n;
  logic          frame_start_n, underrun_n;
  logic          accept, frame_load;

  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      stg_l       <= '0;
      stg_r       <= '0;
      stg_full    <= 1'b0;
      act_l       <= '0;
      act_r       <= '0;
      sh          <= '0;
      bitcnt      <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_n;
      stg_l       <= stg_l_n;
      stg_r       <= stg_r_n;
      stg_full    <= stg_full_n;
      act_l       <= act_l_n;
      act_r       <= act_r_n;
      sh          <= sh_n;
      bitcnt      <= bitcnt_n;
      frame_start <= frame_start_n;
      underrun    <= underrun_n;
    end
  end

  // LRCK edges take priority over a coincident BCLK fall: the MSB is loaded, not shifted.
  always_comb begin
    state_n       = state;
    stg_l_n       = stg_l;
    stg_r_n       = stg_r;
    stg_full_n    = stg_full;
    act_l_n       = act_l;
    act_r_n       = act_r;
    sh_n          = sh;
    bitcnt_n      = bitcnt;
    frame_start_n = 1'b0;
    underrun_n    = 1'b0;
    accept        = in_valid & ~stg_full;
    frame_load    = lrck_rise & (state != LEFT);

    if (accept) begin
      stg_l_n    = in_left;
      stg_r_n    = in_right;
      stg_full_n = 1'b1;
    end

    if (frame_load) begin
      state_n       = LEFT;
      frame_start_n = 1'b1;
      if (stg_full) begin
        act_l_n    = stg_l;
        act_r_n    = stg_r;
        stg_full_n = 1'b0;
      end else begin
        underrun_n = 1'b1;
`ifdef AUD_DAC_TX_HOLD_EN
        act_l_n = act_l;
        act_r_n = act_r;
`else
        act_l_n = '0;
        act_r_n = '0;
`endif
      end
      sh_n     = act_l_n;
      bitcnt_n = '0;
    end else if (lrck_fall && (state == LEFT)) begin
      state_n  = RIGHT;
      sh_n     = act_r;
      bitcnt_n = '0;
    end else if (bclk_fall && (state != IDLE)) begin
      if (bitcnt < CW'(DW - 1)) begin
        sh_n     = {sh[DW-2:0], 1'b0};
        bitcnt_n = bitcnt + CW'(1);
      end else begin
        bitcnt_n = CW'(DW);
      end
    end
  end

  assign in_ready   = ~stg_full;
  assign AUD_DACDAT = (state != IDLE) && (bitcnt < CW'(DW)) ? sh[DW-1] : 1'b0;

endmodule

// File: tb/tb_aud_dac_tx.sv
// Self-checking bench for aud_dac_tx: slot-level codec model plus handshake/pulse model.
module tb_aud_dac_tx;

  localparam int DW = 16;
  localparam int BH = 160;

  logic          CLOCK_50 = 1'b0;
  logic          RST = 1'b0;
  logic          AUD_BCLK = 1'b1;
  logic          AUD_DACLRCK = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_left = '0;
  logic [DW-1:0] in_right = '0;
  logic          in_ready, AUD_DACDAT, frame_start, underrun;

  int errors = 0;
  int checks = 0;

  aud_dac_tx #(.DW(DW)) dut (
    .CLOCK_50    (CLOCK_50),
    .RST         (RST),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_left     (in_left),
    .in_right    (in_right),
    .AUD_DACDAT  (AUD_DACDAT),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Codec clocks: 64 BCLK per LRCK period, LRCK toggling on BCLK falling edges.
  int slot = 63;
  int bit_slot = 0;
  bit bit_due = 1'b0;

  initial begin
    #3;
    forever begin
      AUD_BCLK    = 1'b0;
      slot        = (slot + 1) % 64;
      AUD_DACLRCK = (slot < 32);
      #BH;
      AUD_BCLK = 1'b1;
      bit_slot = slot;
      bit_due  = 1'b1;
      #BH;
    end
  end

  // Behavioural model: frame-level staging/active buffers, load 3 cycles after a pin LRCK rise.
  logic          m_full = 1'b0;
  logic [DW-1:0] m_stg_l = '0, m_stg_r = '0, m_act_l = '0, m_act_r = '0;
  bit            m_playing = 1'b0;
  bit            m_ready_before;
  int            pend = 0;
  logic          lrck_prev = 1'b0;
  logic          exp_fs = 1'b0, exp_und = 1'b0;
  int            n_accepts = 0;
  int            und_seen = 0;

  task automatic modelReset();
    m_full    = 1'b0;
    m_stg_l   = '0;
    m_stg_r   = '0;
    m_act_l   = '0;
    m_act_r   = '0;
    m_playing = 1'b0;
    pend      = 0;
    exp_fs    = 1'b0;
    exp_und   = 1'b0;
  endtask

  task automatic frameLoad();
    exp_fs = 1'b1;
    if (m_full) begin
      m_act_l = m_stg_l;
      m_act_r = m_stg_r;
      m_full  = 1'b0;
    end else begin
      exp_und = 1'b1;
`ifndef AUD_DAC_TX_HOLD_EN
      m_act_l = '0;
      m_act_r = '0;
`endif
    end
    m_playing = 1'b1;
  endtask

  initial forever begin
    @(posedge CLOCK_50);
    if (!RST) begin
      modelReset();
      lrck_prev = AUD_DACLRCK;
    end else begin
      m_ready_before = !m_full;
      exp_fs  = 1'b0;
      exp_und = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) frameLoad();
      end
      if (in_valid && m_ready_before) begin
        m_stg_l = in_left;
        m_stg_r = in_right;
        m_full  = 1'b1;
        n_accepts++;
      end
      if (AUD_DACLRCK && !lrck_prev) pend = 2;
      lrck_prev = AUD_DACLRCK;
    end
  end

  function automatic logic expBit(input int s);
    int            k;
    logic [DW-1:0] w;
    k = s % 32;
    w = (s < 32) ? m_act_l : m_act_r;
    if (!m_playing || k >= DW) return 1'b0;
    return w[DW-1-k];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Single compare process: handshake and pulses every cycle, data bit once per BCLK rise.
  initial forever begin
    @(negedge CLOCK_50);
    checkOutput("in_ready", in_ready, !m_full);
    checkOutput("frame_start", frame_start, exp_fs);
    checkOutput("underrun", underrun, exp_und);
    if (underrun === 1'b1) und_seen++;
    if (bit_due) begin
      bit_due = 1'b0;
      checkOutput("dacdat", AUD_DACDAT, expBit(bit_slot));
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] l, input logic [DW-1:0] r, input int budget);
    int start;
    start = n_accepts;
    @(negedge CLOCK_50);
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    for (int i = 0; i < budget && n_accepts == start; i++) @(negedge CLOCK_50);
    in_valid = 1'b0;
    checks++;
    if (n_accepts == start) begin
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept, expected one within %0d cycles", budget);
    end
  endtask

  task automatic collectWord(output logic [DW-1:0] word, output logic [DW-1:0] tail);
    word = '0;
    tail = '0;
    for (int i = 0; i < 32; i++) begin
      @(posedge AUD_BCLK);
      #1;
      if (i < DW) word = {word[DW-2:0], AUD_DACDAT};
      else        tail = {tail[DW-2:0], AUD_DACDAT};
    end
  endtask

  task automatic captureWord(input bit left, output logic [DW-1:0] word, output logic [DW-1:0] tail);
    if (left) @(posedge AUD_DACLRCK);
    else      @(negedge AUD_DACLRCK);
    collectWord(word, tail);
  endtask

  logic [DW-1:0] w, t;
  logic [DW-1:0] wq[5];
  int            acc_mark[5];
  int            u0;
  bit            stream_on;
  logic [DW-1:0] seq;
  logic [DW-1:0] hold_l;

  initial begin
    RST = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_dacdat", AUD_DACDAT, 1'b0);
    checkOutput("rst_frame_start", frame_start, 1'b0);
    checkOutput("rst_underrun", underrun, 1'b0);
    RST = 1'b1;

    $display("[TB] first frame A5C3/1234");
    applyStimulus(16'hA5C3, 16'h1234, 3000);
    captureWord(1'b1, w, t);
    checkOutput("first_left", w, 16'hA5C3);
    checkOutput("first_left_tail", t, 16'h0000);
    captureWord(1'b0, w, t);
    checkOutput("first_right", w, 16'h1234);
    checkOutput("first_right_tail", t, 16'h0000);

    $display("[TB] underrun with no new frames");
`ifdef AUD_DAC_TX_HOLD_EN
    hold_l = 16'hA5C3;
`else
    hold_l = 16'h0000;
`endif
    u0 = und_seen;
    captureWord(1'b1, w, t);
    checkOutput("underrun_left_1", w, hold_l);
    captureWord(1'b1, w, t);
    checkOutput("underrun_left_2", w, hold_l);
    checkOutput("underrun_count", und_seen - u0, 2);

    $display("[TB] continuous in_valid stream");
    stream_on = 1'b1;
    seq = 16'd1;
    fork
      begin
        int last;
        last     = n_accepts;
        @(negedge CLOCK_50);
        in_left  = seq;
        in_right = ~seq;
        in_valid = 1'b1;
        while (stream_on) begin
          @(negedge CLOCK_50);
          if (n_accepts != last) begin
            last     = n_accepts;
            seq      = seq + 16'd1;
            in_left  = seq;
            in_right = ~seq;
          end
        end
        in_valid = 1'b0;
      end
      begin
        for (int f = 0; f < 5; f++) begin
          @(posedge AUD_DACLRCK);
          acc_mark[f] = n_accepts;
          collectWord(wq[f], t);
        end
        stream_on = 1'b0;
      end
    join
    for (int f = 0; f < 4; f++) begin
      checkOutput("stream_seq", wq[f+1], wq[f] + 16'd1);
      checkOutput("stream_accepts_per_period", acc_mark[f+1] - acc_mark[f], 1);
    end

    $display("[TB] frame presented in the LRCK rise pulse cycle");
    @(posedge AUD_DACLRCK);
    @(posedge AUD_DACLRCK);
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #2;
    in_valid = 1'b1;
    in_left  = 16'h7E81;
    in_right = 16'h0C30;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    checkOutput("edge_accept_underrun", underrun, 1'b1);
    checkOutput("edge_accept_frame_start", frame_start, 1'b1);
    checkOutput("edge_accept_in_ready", in_ready, 1'b0);
    captureWord(1'b1, w, t);
    checkOutput("edge_accept_next_left", w, 16'h7E81);

    $display("[TB] reset mid left word");
    applyStimulus(16'hFFFF, 16'h00F0, 3000);
    @(posedge AUD_DACLRCK);
    applyStimulus(16'h3C3C, 16'hC3C3, 3000);
    repeat (7) @(posedge AUD_BCLK);
    #40;
    checkOutput("pre_reset_dacdat", AUD_DACDAT, 1'b1);
    checkOutput("pre_reset_in_ready", in_ready, 1'b0);
    RST = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_dacdat", AUD_DACDAT, 1'b0);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    repeat (5) @(negedge CLOCK_50);
    RST = 1'b1;
    captureWord(1'b0, w, t);
    checkOutput("post_reset_right_word", w, 16'h0000);
    checkOutput("post_reset_right_tail", t, 16'h0000);
    u0 = und_seen;
    captureWord(1'b1, w, t);
    checkOutput("post_reset_left_word", w, 16'h0000);
    checkOutput("post_reset_underrun", und_seen - u0, 1);

    $display("[TB] randomized frames and gaps");
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 1200)) @(negedge CLOCK_50);
      applyStimulus(16'($urandom), 16'($urandom), 3000);
    end
    repeat (2) @(posedge AUD_DACLRCK);
    repeat (200) @(negedge CLOCK_50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
